// File: rtl/matmul_result_drain_if.sv
// Bundle of the drain block's control, result-memory read port and output stream.
// The DUT uses the master modport; the environment (host + memory) uses slave.
interface matmul_result_drain_if #(
    parameter int unsigned N  = 32,
    parameter int unsigned DW = 32
);
    localparam int unsigned AW = $clog2(N * N);

    logic          start;
    logic          transpose;
    logic          abort;
    logic          busy;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;

    modport master (
        input  start, transpose, abort, rd_data, m_ready,
        output busy, done, rd_en, rd_addr, m_valid, m_data, m_last
    );

    modport slave (
        output start, transpose, abort, rd_data, m_ready,
        input  busy, done, rd_en, rd_addr, m_valid, m_data, m_last
    );
endinterface

// File: rtl/matmul_result_drain.sv
// Walks the N*N result memory (row- or column-major) and streams each word out through a
// small FIFO that absorbs the one-cycle read latency and host back-pressure.
module matmul_result_drain #(
    parameter int unsigned N          = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    matmul_result_drain_if.master   bus
);
    localparam int unsigned AW = $clog2(N * N);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [AW-1:0] LastIdx = AW'(N * N - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   iss_q, iss_d;
    logic [AW-1:0]   snt_q, snt_d;
    logic            trans_q, trans_d;
    logic            pend_q, pend_d;
    logic            done_q, done_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [DW-1:0]   fifo_q [FIFO_DEPTH];
    logic [DW-1:0]   fifo_d [FIFO_DEPTH];

    logic            accept, cancel, rd_en, m_valid, m_last, pop;
    logic [CW:0]     occ;
    logic [AW-1:0]   rd_addr;

    assign accept = (state_q == StIdle) && bus.start;
    assign cancel = (state_q != StIdle) && bus.abort;
    assign pop    = m_valid && bus.m_ready;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.start) state_d = StRead;
            StRead: begin
                if (bus.abort)                        state_d = StIdle;
                else if (rd_en && (iss_q == LastIdx)) state_d = StDrain;
            end
            StDrain: begin
                if (bus.abort)          state_d = StIdle;
                else if (pop && m_last) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; the in-flight read reserves a slot so the FIFO can never overflow
    always_comb begin
        occ     = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};
        rd_en   = (state_q == StRead) && !bus.abort && (occ < (CW + 1)'(FIFO_DEPTH));
        m_valid = (cnt_q != '0);
        m_last  = m_valid && (snt_q == LastIdx);
        if (trans_q) rd_addr = AW'((32'(iss_q) % N) * N + 32'(iss_q) / N);
        else         rd_addr = iss_q;
    end

    assign bus.rd_en   = rd_en;
    assign bus.rd_addr = rd_addr;
    assign bus.busy    = (state_q != StIdle);
    assign bus.done    = done_q;
    assign bus.m_valid = m_valid;
    assign bus.m_data  = fifo_q[rd_ptr_q];
    assign bus.m_last  = m_last;

    // Datapath next state: counters, FIFO and the single in-flight read
    always_comb begin
        iss_d    = iss_q;
        snt_d    = snt_q;
        trans_d  = trans_q;
        pend_d   = 1'b0;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fifo_d   = fifo_q;
        done_d   = 1'b0;
        if (accept || cancel) begin
            if (accept) trans_d = bus.transpose;
            iss_d    = '0;
            snt_d    = '0;
            cnt_d    = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (rd_en) begin
                iss_d  = iss_q + AW'(1);
                pend_d = 1'b1;
            end
            if (pend_q) begin
                fifo_d[wr_ptr_q] = bus.rd_data;
                wr_ptr_d         = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                snt_d    = snt_q + AW'(1);
            end
            cnt_d  = cnt_q + CW'(pend_q) - CW'(pop);
            done_d = (state_q == StDrain) && pop && m_last;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iss_q    <= '0;
            snt_q    <= '0;
            trans_q  <= 1'b0;
            pend_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fifo_q   <= '{default: '0};
        end else begin
            iss_q    <= iss_d;
            snt_q    <= snt_d;
            trans_q  <= trans_d;
            pend_q   <= pend_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fifo_q   <= fifo_d;
        end
    end
endmodule

// File: tb/tb_matmul_result_drain.sv
// Directed + randomized bench for matmul_result_drain; expected stream order and data come
// from the traversal rule applied to a behavioural memory.
module tb_matmul_result_drain;
    localparam int N     = 32;
    localparam int NN    = N * N;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset_n;
    matmul_result_drain_if #(.N(N), .DW(32)) bus ();

    matmul_result_drain #(.N(N), .DW(32), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [NN];
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    int          tests = 0, failed = 0;
    int          issued, popped, cyc, done_cnt, done_cyc, last_hs_cyc;
    bit          trans_m, armed, prev_stall, prev_rd;
    logic [31:0] prev_data;

    function automatic int order(input int k);
        return trans_m ? (k % N) * N + k / N : k;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_clear();
        issued = 0; popped = 0; cyc = 0; done_cnt = 0; done_cyc = -1;
        last_hs_cyc = -10; armed = 0; prev_stall = 0; prev_rd = 0;
    endtask

    // One clock: sample mid-cycle, check against the model, then advance past the edge.
    task automatic step();
        @(negedge clk);
        if (armed) begin
            if (cyc == 1) begin
                chk("busy_c1", bus.busy, 1);
                chk("rd_en_c1", bus.rd_en, 1);
                chk("rd_addr_c1", bus.rd_addr, 0);
            end
            if (cyc == 2) chk("valid_c2", bus.m_valid, 0);
            if (cyc == 3) chk("valid_c3", bus.m_valid, 1);
        end
        if (bus.rd_en) begin
            chk("rd_addr", bus.rd_addr, order(issued));
            chk("outstanding_lt_depth", (issued - popped) < DEPTH, 1);
            issued++;
        end
        if (prev_stall) begin
            chk("stall_valid", bus.m_valid, 1);
            chk("stall_data", bus.m_data, prev_data);
        end
        if (bus.m_valid) begin
            chk("m_data", bus.m_data, mem[order(popped)]);
            chk("m_last", bus.m_last, popped == NN - 1);
        end else begin
            chk("m_last_no_valid", bus.m_last, 0);
        end
        if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("done_after_last", cyc, last_hs_cyc + 1);
            chk("busy_at_done", bus.busy, 0);
        end
        if (bus.m_valid && bus.m_ready) begin
            popped++;
            if (popped == NN) last_hs_cyc = cyc;
        end
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_rd    = bus.rd_en;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input bit t);
        model_clear();
        trans_m       = t;
        bus.start     = 1'b1;
        bus.transpose = t;
        step();
        bus.start     = 1'b0;
        bus.transpose = !t;
        armed         = 1;
    endtask

    task automatic run_to_done(input int budget, input bit rand_ready);
        int n = 0, hold = 0;
        bit hold_done = 0;
        while (done_cnt == 0 && n < budget) begin
            if (rand_ready) begin
                if (hold > 0) begin
                    bus.m_ready = 1'b0;
                    hold--;
                end else begin
                    bus.m_ready = 1'($urandom_range(0, 1));
                end
            end
            step();
            n++;
            if (rand_ready && !hold_done && popped == 6) begin
                hold = 20;
                hold_done = 1;
            end
        end
        chk("run_done_seen", done_cnt, 1);
        chk("handshakes", popped, NN);
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (popped < target && n < budget) begin
            step();
            n++;
        end
        chk("reach_target", popped, target);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_rd_en"}, bus.rd_en, 0);
        chk({tag, "_rd_addr"}, bus.rd_addr, 0);
        chk({tag, "_m_valid"}, bus.m_valid, 0);
        chk({tag, "_m_last"}, bus.m_last, 0);
    endtask

    initial begin
        int n;
        reset_n       = 1'b0;
        bus.start     = 1'b0;
        bus.transpose = 1'b0;
        bus.abort     = 1'b0;
        bus.m_ready   = 1'b0;
        for (int i = 0; i < NN; i++) mem[i] = 32'(i);
        model_clear();

        // Reset state
        @(negedge clk);
        chk_reset_outs("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Row-major, ready held high
        bus.m_ready = 1'b1;
        do_start(0);
        run_to_done(1200, 0);
        chk("row_done_cycle", done_cyc, 1027);

        // Column-major
        do_start(1);
        run_to_done(1200, 0);
        chk("col_done_cycle", done_cyc, 1027);

        // Back-pressure with random contents and traversal order
        for (int i = 0; i < NN; i++) mem[i] = $urandom;
        do_start(1'($urandom_range(0, 1)));
        run_to_done(8000, 1);
        for (int i = 0; i < NN; i++) mem[i] = 32'(i);

        // Abort with three words buffered and one read in flight at element 100
        bus.m_ready = 1'b1;
        do_start(0);
        n = 0;
        while (!(popped == 100 && (issued - popped) == 4 && prev_rd) && n < 500) begin
            bus.m_ready = (popped < 100);
            step();
            n++;
        end
        chk("abort_setup", popped == 100 && (issued - popped) == 4 && prev_rd, 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        model_clear();
        chk("abort_m_valid", bus.m_valid, 0);
        chk("abort_busy", bus.busy, 0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        chk("abort_no_done", done_cnt, 0);
        chk("abort_no_reads", issued, 0);
        do_start(0);
        run_to_done(1200, 0);

        // Asynchronous reset mid-drain
        do_start(0);
        run_until(500, 700);
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_outs("midreset");
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_start(0);
        run_to_done(1200, 0);
        chk("reset_restart_done_cycle", done_cyc, 1027);

        // Start while busy is ignored
        do_start(0);
        run_until(10, 100);
        bus.start     = 1'b1;
        bus.transpose = 1'b1;
        step();
        bus.start     = 1'b0;
        bus.transpose = 1'b0;
        run_to_done(1200, 0);
        chk("busy_start_done_cycle", done_cyc, 1027);
        for (int i = 0; i < 5; i++) step();
        chk("busy_start_one_done", done_cnt, 1);
        chk("busy_start_idle_valid", bus.m_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
